// File: rtl/mult_rr_sched.sv
// mult_rr_sched
// Round-robin front end that shares one external 4x4 multiplier among NREQ
// requesters.
// - A request is granted only while the block is idle, and one operation runs at a time.
// - The operands are latched when the request is granted.
// - The product is captured after LAT cycles and held until the consumer takes it.
//
// Optional feature: define MULT_SCHED_STATS_EN to add op_count/stall_count.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no operation in flight; arbitrate among req_valid
// ISSUE  | one-cycle req_ready pulse to the winner, operands on mul_in*
// WAIT   | multiplier latency countdown, product captured on last cycle
// RESP   | rsp_valid held with stable id/data until rsp_ready
module mult_rr_sched #(
   parameter int NREQ = 4,
   parameter int LAT  = 1
) (
   input  logic                      clk,
   input  logic                      reset_vio,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [4*NREQ-1:0]         req_a,
   input  logic [4*NREQ-1:0]         req_b,
   output logic [NREQ-1:0]           req_ready,
   output logic [3:0]                mul_in1,
   output logic [3:0]                mul_in2,
   input  logic [7:0]                mul_out,
   output logic                      rsp_valid,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [7:0]                rsp_data,
   input  logic                      rsp_ready,
`ifdef MULT_SCHED_STATS_EN
   output logic                      busy,
   output logic [15:0]               op_count,
   output logic [15:0]               stall_count
`else
   output logic                      busy
`endif
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           r_state;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   r_gnt;
   logic [CW-1:0]    r_cnt;

   logic             w_any;
   logic [IDW-1:0]   w_sel;
   logic [3:0]       w_a;
   logic [3:0]       w_b;
   int               w_j;

   // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      w_a   = '0;
      w_b   = '0;
      w_j   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_j = (int'(r_rr_ptr) + k) % NREQ;
         if (req_valid[w_j]) begin
            w_any = 1'b1;
            w_sel = IDW'(w_j);
            w_a   = req_a[4*w_j +: 4];
            w_b   = req_b[4*w_j +: 4];
         end
      end
   end

   // Scheduler FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset_vio) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_gnt     <= '0;
         r_cnt     <= '0;
         req_ready <= '0;
         mul_in1   <= '0;
         mul_in2   <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         busy      <= 1'b0;
      end else begin
         req_ready <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt     <= w_sel;
                  req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
                  mul_in1   <= w_a;
                  mul_in2   <= w_b;
                  busy      <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_gnt == IDW'(NREQ - 1)) begin
                  r_rr_ptr <= '0;
               end else begin
                  r_rr_ptr <= r_gnt + 1'b1;
               end
               r_cnt   <= CW'(LAT);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  rsp_data  <= mul_out;
                  rsp_id    <= r_gnt;
                  rsp_valid <= 1'b1;
                  mul_in1   <= '0;
                  mul_in2   <= '0;
                  r_state   <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef MULT_SCHED_STATS_EN
   // Completed handshakes wrap; back-pressure cycles saturate.
   always_ff @(posedge clk) begin
      if (reset_vio) begin
         op_count    <= '0;
         stall_count <= '0;
      end else if (r_state == S_RESP) begin
         if (rsp_ready) begin
            op_count <= op_count + 16'd1;
         end else if (stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mult_rr_sched.sv
// Testbench for mult_rr_sched.
// The bench contains a latency-LAT multiplier model and a timeline reference
// model. The reference model counts cycles from each grant decision.
module tb_mult_rr_sched;

   localparam int NREQ = 4;
   localparam int LAT  = 2;
   localparam int IDW  = $clog2(NREQ);

   logic                 clk = 1'b0;
   logic                 reset_vio;
   logic [NREQ-1:0]      req_valid;
   logic [4*NREQ-1:0]    req_a;
   logic [4*NREQ-1:0]    req_b;
   logic [NREQ-1:0]      req_ready;
   logic [3:0]           mul_in1;
   logic [3:0]           mul_in2;
   logic [7:0]           mul_out;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [7:0]           rsp_data;
   logic                 rsp_ready;
   logic                 busy;
`ifdef MULT_SCHED_STATS_EN
   logic [15:0]          op_count;
   logic [15:0]          stall_count;
`endif

   always #5 clk = ~clk;

   mult_rr_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk         (clk),
      .reset_vio   (reset_vio),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .mul_in1     (mul_in1),
      .mul_in2     (mul_in2),
      .mul_out     (mul_out),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_ready   (rsp_ready),
`ifdef MULT_SCHED_STATS_EN
      .busy        (busy),
      .op_count    (op_count),
      .stall_count (stall_count)
`else
      .busy        (busy)
`endif
   );

   // Shared multiplier: the product appears LAT cycles after the operands.
   logic [7:0] mul_pipe [LAT];
   always @(posedge clk) begin
      if (reset_vio) begin
         for (int i = 0; i < LAT; i++) mul_pipe[i] <= 8'd0;
      end else begin
         mul_pipe[0] <= 8'(mul_in1) * 8'(mul_in2);
         for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
      end
   end
   assign mul_out = mul_pipe[LAT-1];

   int n_vec = 0;
   int n_err = 0;

   // Reference model. m_age is the number of cycles since the grant decision.
   // The phases by age are:
   //   1            req_ready pulse.
   //   1..LAT+1     operands present on mul_in1/mul_in2.
   //   >= LAT+2     response is pending.
   int  m_age   = -1;
   int  m_ptr   = 0;
   int  m_id    = 0;
   int  m_a     = 0;
   int  m_b     = 0;
   int  m_ops   = 0;
   int  m_stall = 0;
   bit  m_rst   = 1'b0;
   int  dut_grants [$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (reset_vio) begin
         m_age   = -1;
         m_ptr   = 0;
         m_ops   = 0;
         m_stall = 0;
         m_rst   = 1'b1;
      end else begin
         m_rst = 1'b0;
         if (m_age < 0) begin
            if (req_valid != '0) begin
               for (int k = NREQ - 1; k >= 0; k--) begin
                  int j;
                  j = (m_ptr + k) % NREQ;
                  if (req_valid[j]) m_id = j;
               end
               m_a   = int'(req_a[4*m_id +: 4]);
               m_b   = int'(req_b[4*m_id +: 4]);
               m_ptr = (m_id + 1) % NREQ;
               m_age = 1;
            end
         end else if (m_age >= LAT + 2) begin
            if (rsp_ready) begin
               m_age = -1;
               m_ops = (m_ops + 1) % 65536;
            end else if (m_stall < 65535) begin
               m_stall++;
            end
         end else begin
            m_age++;
         end
      end
   endtask

   task automatic check_outputs();
      check_eq("req_ready", 32'(req_ready), (m_age == 1) ? 32'(1 << m_id) : 32'd0);
      check_eq("busy", 32'(busy), 32'(m_age >= 1));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(m_age >= LAT + 2));
      if (m_age <= LAT + 1) begin
         check_eq("mul_in1", 32'(mul_in1), (m_age >= 1) ? 32'(m_a) : 32'd0);
         check_eq("mul_in2", 32'(mul_in2), (m_age >= 1) ? 32'(m_b) : 32'd0);
      end
      if (m_age >= LAT + 2) begin
         check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
         check_eq("rsp_data", 32'(rsp_data), 32'(m_a * m_b));
      end
      if (m_rst) begin
         check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
         check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
      end
`ifdef MULT_SCHED_STATS_EN
      check_eq("op_count", 32'(op_count), 32'(m_ops));
      check_eq("stall_count", 32'(stall_count), 32'(m_stall));
`endif
      if (req_ready != '0) begin
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_grants.push_back(i);
      end
   endtask

   task automatic cyc(input logic rst, input logic [NREQ-1:0] v,
                      input logic [4*NREQ-1:0] a, input logic [4*NREQ-1:0] b,
                      input logic rdy);
      reset_vio = rst;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = rdy;
      @(posedge clk);
      #1;
      model_edge();
      check_outputs();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, rdy);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, '0, '0, '0, 1'b1);
   endtask

   // One operation from a single requester with nstall back-pressure cycles.
   task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b, input int nstall);
      logic [4*NREQ-1:0] pa;
      logic [4*NREQ-1:0] pb;
      pa = '0;
      pb = '0;
      pa[4*id +: 4] = a;
      pb[4*id +: 4] = b;
      cyc(1'b0, NREQ'(1 << id), pa, pb, 1'b1);
      idle(LAT + 1, 1'b0);
      idle(nstall, 1'b0);
      idle(1, 1'b1);
      idle(1, 1'b1);
   endtask

   initial begin
      logic [4*NREQ-1:0] pa;
      int                base;

      do_reset(3);

      // Single request: 3 x 5 from requester 0.
      dut_grants.delete();
      do_op(0, 4'd3, 4'd5, 0);
      check_eq("single_grant_count", 32'(dut_grants.size()), 32'd1);
      check_eq("single_grant_id", (dut_grants.size() > 0) ? 32'(dut_grants[0]) : 32'hFFFF, 32'd0);

      // All requesters active from reset: a=i+1, b=2.
      do_reset(2);
      dut_grants.delete();
      pa = '0;
      for (int i = 0; i < NREQ; i++) pa[4*i +: 4] = 4'(i + 1);
      for (int i = 0; i < 5 * (LAT + 3); i++) cyc(1'b0, '1, pa, {NREQ{4'd2}}, 1'b1);
      idle(LAT + 4, 1'b1);
      check_eq("rot_count", 32'(dut_grants.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         check_eq("rot_order", (dut_grants.size() > i) ? 32'(dut_grants[i]) : 32'hFFFF, 32'(i % NREQ));

      // Back-pressure: 15 x 15 from requester 1 while others keep requesting.
      base = dut_grants.size();
      cyc(1'b0, 4'b0010, 16'h00F0, 16'h00F0, 1'b0);
      for (int i = 0; i < LAT + 1 + 5; i++) cyc(1'b0, 4'b1101, 16'hFFFF, 16'hFFFF, 1'b0);
      cyc(1'b0, '0, '0, '0, 1'b1);
      idle(3, 1'b1);
      check_eq("bp_grants", 32'(dut_grants.size() - base), 32'd1);

      // Wrap: grant 2 alone so that rr_ptr becomes 3, then requesters 1 and 3 request.
      do_reset(2);
      dut_grants.delete();
      do_op(2, 4'd2, 4'd2, 0);
      for (int i = 0; i < 2 * (LAT + 3); i++) cyc(1'b0, 4'b1010, 16'h5A3C, 16'h9E71, 1'b1);
      idle(LAT + 4, 1'b1);
      check_eq("wrap_count", 32'(dut_grants.size()), 32'd3);
      check_eq("wrap_first", (dut_grants.size() > 1) ? 32'(dut_grants[1]) : 32'hFFFF, 32'd3);
      check_eq("wrap_second", (dut_grants.size() > 2) ? 32'(dut_grants[2]) : 32'hFFFF, 32'd1);

      // Reset during WAIT abandons the operation; requester 2 is then granted normally.
      dut_grants.delete();
      cyc(1'b0, 4'b0100, 16'h0700, 16'h0300, 1'b1);
      idle(2, 1'b1);
      do_reset(1);
      idle(3, 1'b1);
      do_op(2, 4'd7, 4'd3, 0);
      check_eq("rstwait_grants", 32'(dut_grants.size()), 32'd2);

`ifdef MULT_SCHED_STATS_EN
      do_reset(2);
      do_op(0, 4'd1, 4'd9, 1);
      do_op(1, 4'd4, 4'd4, 0);
      do_op(3, 4'd15, 4'd15, 3);
      check_eq("stats_ops", 32'(op_count), 32'd3);
      check_eq("stats_stalls", 32'(stall_count), 32'd4);
`endif

      // Randomised traffic: dropping requests, back-pressure and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         logic              r;
         logic [NREQ-1:0]   v;
         r = ($urandom_range(0, 249) == 0);
         v = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
         cyc(r, v, (4*NREQ)'($urandom), (4*NREQ)'($urandom), ($urandom_range(0, 3) != 0));
      end
      idle(LAT + 4, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mult_rr_sched.md
MULT_RR_SCHED -- requirements
Module: mult_rr_sched

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one multiplier (2..8).
REQ-002 Parameter: LAT, 1, cycles from operands stable on mul_in1/mul_in2 to a valid product on mul_out (1..4).
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset_vio  in  1  synchronous, active-high reset.
REQ-005 Port: req_valid  in  NREQ  per-requester request strobe; bit i belongs to requester i.
REQ-006 Port: req_a  in  4*NREQ  packed operand A; bits [4i+3:4i] belong to requester i.
REQ-007 Port: req_b  in  4*NREQ  packed operand B, same packing as req_a.
REQ-008 Port: req_ready  out  NREQ  one-hot acceptance pulse to the granted requester.
REQ-009 Port: mul_in1  out  4  operand A to the shared multiplier.
REQ-010 Port: mul_in2  out  4  operand B to the shared multiplier.
REQ-011 Port: mul_out  in  8  registered product returned by the shared multiplier.
REQ-012 Port: rsp_valid  out  1  result available.
REQ-013 Port: rsp_id  out  ceil(log2(NREQ))  index of the requester that owns the result.
REQ-014 Port: rsp_data  out  8  product.
REQ-015 Port: rsp_ready  in  1  result consumer accepts.
REQ-016 Port: busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if any req_valid bit is high, select the first set bit at or above rr_ptr, wrapping modulo NREQ, latch its index and operands, and go to ISSUE; otherwise remain in IDLE.
REQ-019 ISSUE (one cycle): req_ready[granted]=1, all other bits 0; drive the latched operands onto mul_in1/mul_in2; set rr_ptr = (granted+1) mod NREQ; load the wait counter with LAT; go to WAIT.
REQ-020 mul_in1/mul_in2 SHALL hold the latched operands from ISSUE until the result is captured, and SHALL be 0 in IDLE.
REQ-021 WAIT: decrement the counter each cycle; in the cycle it reaches 0, capture mul_out into rsp_data, set rsp_id to the granted index, and go to RESP.
REQ-022 RESP: rsp_valid=1; rsp_data and rsp_id held stable until rsp_ready=1; on rsp_valid and rsp_ready both high, go to IDLE with rsp_valid=0 on the next cycle.
REQ-023 An operation SHALL take LAT+3 cycles, from the IDLE grant decision to the IDLE return, when rsp_ready is held high.
REQ-024 New requests SHALL be ignored outside IDLE, and only one operation SHALL be in flight at a time.
REQ-025 A req_valid that drops before it is granted SHALL be silently dropped, and it SHALL NOT receive req_ready.
REQ-026 With all requesters continuously active, grants SHALL rotate 0,1,...,NREQ-1,0, so no requester waits more than NREQ-1 operations.
REQ-027 Products SHALL be zero-extended 4x4 to 8 bits; rsp_data SHALL equal mul_out as captured and SHALL NOT be truncated.

Reset
REQ-028 While reset_vio=1 at a clock edge: state=IDLE, rr_ptr=0, and the counter, req_ready, mul_in1, mul_in2, rsp_valid, rsp_id, rsp_data and busy all go to 0.
REQ-029 Reset in any state SHALL abandon the in-flight operation with no response issued, and the first grant after reset SHALL follow rr_ptr=0.

Configuration
REQ-030 Macro MULT_SCHED_STATS_EN defined: add output op_count (16 bits, one per completed RESP handshake, wraps FFFF->0000) and output stall_count (16 bits, one per RESP cycle with rsp_ready=0, saturates at FFFF); both clear on reset.
REQ-031 MULT_SCHED_STATS_EN undefined: neither port nor any counter logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-032 Single request: req_valid=0001, a=3, b=5, rsp_ready=1 -> req_ready=0001 for one cycle; rsp_valid with rsp_id=0 and rsp_data=15, exactly LAT+1 cycles after ISSUE.
REQ-033 All four requesting, from reset: a=i+1 and b=2 -> grant order 0,1,2,3,0; results 2,4,6,8 tagged with ids 0..3.
REQ-034 Back-pressure: 15x15 with rsp_ready low for 5 cycles -> rsp_valid held; rsp_data=225 stable; no new grant; IDLE the cycle after the handshake.
REQ-035 Wrap: rr_ptr=3, requesters 1 and 3 active -> 3 granted first, then 1.
REQ-036 Reset in WAIT: reset_vio pulsed -> no rsp_valid; outputs 0; next request from requester 2 alone granted normally.
REQ-037 With MULT_SCHED_STATS_EN defined: 3 operations with 4 total stall cycles -> op_count=3, stall_count=4.
